rf_write_arbiter: RTL and testbench
===================================

Name: rf_write_arbiter

Overview:
Shares the register file's single write port between two requesters. The first is the in-order pipeline writeback stage (WB), which has fixed priority. The second is the long-latency multiply/divide unit (MDU), whose results are queued in a small FIFO. The block keeps a per-register pending-write scoreboard for the hazard unit. It raises a pipeline stall request when queued MDU results would otherwise starve. Registered outputs drive the register file's regwrite/write_addr/write_data inputs directly.

Parameters:
ADDR_SIZE, 5, register address width (2**ADDR_SIZE registers)
WORD, 32, data width
QDEPTH, 2, MDU result FIFO depth (power of 2, >=2)
STARVE_LIMIT, 3, cycles a FIFO head may wait before stall is requested

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous active-high reset
wb_we  in  1  WB write request
wb_addr  in  ADDR_SIZE  WB destination
wb_data  in  WORD  WB data
mdu_valid  in  1  MDU result valid
mdu_ready  out  1  FIFO can accept MDU result
mdu_addr  in  ADDR_SIZE  MDU destination
mdu_data  in  WORD  MDU data
iss_valid  in  1  MDU operation issued this cycle
iss_addr  in  ADDR_SIZE  destination of issued MDU op
busy_vec  out  2**ADDR_SIZE  per-register pending MDU write bits
pipe_stall  out  1  request to hazard unit: hold WB (wb_we must be 0 next cycle)
rf_regwrite  out  1  register file write enable
rf_write_addr  out  ADDR_SIZE  register file write address
rf_write_data  out  WORD  register file write data

Behaviour:
- Clock/reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset state: rf_regwrite=0, rf_write_addr=0, rf_write_data=0; FIFO empty; busy_vec=0; age counter=0; pipe_stall=0.
- While rst=1, mdu_ready=0. Otherwise mdu_ready = !full, computed from registered count.
- Output timing: rf_* are registered, so a granted request appears on rf_* one cycle after it is presented. The values stay stable through the following low clock phase, which is when the register file commits.
- Register 0: the register file does not hard-wire r0.
  - WB request with wb_addr=0: no grant; rf_regwrite=0 that cycle.
  - MDU result with addr 0: handshake completes normally, the entry is popped, and nothing is written.
  - iss_valid with iss_addr=0: ignored.
- Push: FIFO pushes when mdu_valid && mdu_ready. There is no same-cycle bypass; the earliest commit is the cycle after the push.
- Arbitration each cycle, in priority order:
  1. wb_we && wb_addr!=0: grant WB.
  2. Else FIFO non-empty: pop head and grant it (suppressed if head addr is 0).
  3. Else rf_regwrite=0.
- rf_write_addr and rf_write_data hold their last values when idle.
- Same-cycle push and pop: count is unchanged; the pointers wrap modulo QDEPTH.
- Age counter: increments each cycle the FIFO is non-empty and the head is not popped, saturating at STARVE_LIMIT. It clears on a pop or when the FIFO is empty.
- pipe_stall (registered): asserted the cycle after (count==QDEPTH || age==STARVE_LIMIT). It deasserts the cycle after neither condition holds.
  - If wb_we=1 while pipe_stall=1, WB still wins. This is a protocol violation.
- busy_vec:
  - Set bit iss_addr on iss_valid.
  - Clear bit addr when a FIFO entry with that addr is popped.
  - Set and clear of the same bit in the same cycle: set wins.
  - Issuing to an already-busy register leaves the bit set; preventing this is the hazard unit's job.
  - Bit 0 is always 0.
- Reset mid-operation: queued entries are discarded without being written, and busy_vec is cleared.

Optional Feature:
- Macro: RF_ARB_TRACE_EN.
- Defined: on each rising edge with rf_regwrite=1 after the update, $display a line with the time, the source (WB or MDU), the address and the data (hex). A dropped r0 MDU entry prints "MDU r0 dropped".
- Undefined: no display code is compiled; behaviour is otherwise identical.

Test Plan:
- Reset with rst=1 for 2 cycles while mdu_valid=1 -> mdu_ready=0, rf_regwrite=0, busy_vec=0 throughout. mdu_ready=1 in the first cycle after rst falls.
- wb_we=1, wb_addr=8, wb_data=0x12345678 for one cycle -> next cycle rf_regwrite=1, rf_write_addr=8, rf_write_data=0x12345678. Repeat with wb_addr=0 -> rf_regwrite=0.
- iss_valid with iss_addr=16. Later, mdu_valid with addr 16, data 0xDEADBEEF, and WB idle -> busy_vec[16]=1 until the pop. The write appears 2 cycles after mdu_valid and busy_vec[16] clears on the same edge.
- WB continuously writing r9. Push MDU results to r17 and r18 -> mdu_ready=0 after the 2nd push and pipe_stall=1 the next cycle. After wb_we drops: r17 then r18 are written on consecutive cycles, then pipe_stall=0.
- Single MDU entry blocked by continuous WB -> pipe_stall rises exactly STARVE_LIMIT+1 cycles after the push.
- iss_valid to r20 on the same cycle as a pop of an r20 entry -> busy_vec[20] stays 1. Reset asserted with 2 entries queued -> neither entry is ever written.

Source files
------------

// File: rtl/rf_write_arbiter.sv
// ---------------------------------------------------------------------------
// rf_write_arbiter
//
// This block shares the register file's single write port between two
// requesters:
//   * WB  : the in-order writeback stage. It has fixed priority and is never
//           queued.
//   * MDU : the long-latency multiply/divide unit. Its results go into a
//           small FIFO and drain whenever WB leaves the port idle.
//
// The block also does two other jobs:
//   * It keeps a per-register pending-write scoreboard (busy_vec) for the
//     hazard unit. A bit is set when an MDU op is issued to a register and
//     cleared when that register's result leaves the FIFO.
//   * It raises pipe_stall when queued MDU results are at risk of starving.
//     That happens when the FIFO is full, or when the head entry has waited
//     STARVE_LIMIT cycles.
//
// Parameters
//   ADDR_SIZE    : register address width (2**ADDR_SIZE registers)
//   WORD         : data width
//   QDEPTH       : MDU result FIFO depth (power of 2, >= 2)
//   STARVE_LIMIT : cycles a FIFO head may wait before a stall is requested
//
// Ports
//   clk, rst                          : clock; synchronous active-high reset
//   wb_we, wb_addr, wb_data           : WB write request
//   mdu_valid, mdu_addr, mdu_data     : MDU result offered to the FIFO
//   mdu_ready                         : FIFO can accept an MDU result
//   iss_valid, iss_addr               : MDU op issued this cycle (sets busy)
//   busy_vec                          : per-register pending MDU write bits
//   pipe_stall                        : registered request to hold WB
//   rf_regwrite, rf_write_addr,
//   rf_write_data                     : registered register-file write port
//
// Optional build macro
//   RF_ARB_TRACE_EN : when defined, every committed write (and every dropped
//                     r0 MDU entry) prints one trace line. No trace code is
//                     compiled when the macro is undefined.
//
// Register 0 is not hard-wired in the register file, so this block never
// writes it:
//   * WB requests to r0 are not granted.
//   * MDU entries for r0 are popped but not written.
//   * Issues to r0 are ignored.
// ---------------------------------------------------------------------------
module rf_write_arbiter #(
  parameter int unsigned ADDR_SIZE    = 5,
  parameter int unsigned WORD         = 32,
  parameter int unsigned QDEPTH       = 2,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wb_we,
  input  logic [ADDR_SIZE-1:0]    wb_addr,
  input  logic [WORD-1:0]         wb_data,
  input  logic                    mdu_valid,
  output logic                    mdu_ready,
  input  logic [ADDR_SIZE-1:0]    mdu_addr,
  input  logic [WORD-1:0]         mdu_data,
  input  logic                    iss_valid,
  input  logic [ADDR_SIZE-1:0]    iss_addr,
  output logic [2**ADDR_SIZE-1:0] busy_vec,
  output logic                    pipe_stall,
  output logic                    rf_regwrite,
  output logic [ADDR_SIZE-1:0]    rf_write_addr,
  output logic [WORD-1:0]         rf_write_data
);

  localparam int unsigned NREG = 2**ADDR_SIZE;
  localparam int unsigned PW   = $clog2(QDEPTH);
  // The count must be able to hold QDEPTH itself, so it needs one extra bit
  // beyond the pointer width.
  localparam int unsigned CW   = PW + 1;
  localparam int unsigned AW   = $clog2(STARVE_LIMIT + 1);

  localparam logic [CW-1:0] FULL_CNT  = CW'(QDEPTH);
  localparam logic [AW-1:0] AGE_LIMIT = AW'(STARVE_LIMIT);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------

  // FIFO storage: data-only, no reset needed.
  logic [ADDR_SIZE-1:0] fifo_addr_q [QDEPTH];
  logic [WORD-1:0]      fifo_data_q [QDEPTH];

  // Control state: reset.
  logic [PW-1:0]        wr_ptr_q,        wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q,        rd_ptr_d;
  logic [CW-1:0]        count_q,         count_d;
  logic [AW-1:0]        age_q,           age_d;
  logic                 pipe_stall_q,    pipe_stall_d;
  logic [NREG-1:0]      busy_q,          busy_d;
  logic                 rf_regwrite_q,   rf_regwrite_d;
  logic [ADDR_SIZE-1:0] rf_write_addr_q, rf_write_addr_d;
  logic [WORD-1:0]      rf_write_data_q, rf_write_data_d;

  // -------------------------------------------------------------------------
  // Combinational handshake and arbitration
  // -------------------------------------------------------------------------
  logic                 fifo_empty;
  logic                 fifo_full;
  logic                 push;
  logic                 pop;
  logic                 grant_wb;
  logic [ADDR_SIZE-1:0] head_addr;
  logic [WORD-1:0]      head_data;
  logic                 head_is_r0;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FULL_CNT);

  // mdu_ready looks at the registered count only. It never depends on this
  // cycle's pop, so there is no combinational path from wb_we to mdu_ready.
  assign mdu_ready  = !rst && !fifo_full;
  assign push       = mdu_valid && mdu_ready;

  assign head_addr  = fifo_addr_q[rd_ptr_q];
  assign head_data  = fifo_data_q[rd_ptr_q];
  assign head_is_r0 = (head_addr == '0);

  // WB wins whenever it targets a real register. This holds even while
  // pipe_stall is up: the hazard unit is responsible for honouring the stall.
  assign grant_wb   = wb_we && (wb_addr != '0);

  // An r0 head is still popped. It just produces no write.
  assign pop        = !grant_wb && !fifo_empty;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    // Pointers wrap naturally because QDEPTH is a power of two.
    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end

    // A simultaneous push and pop leaves the count unchanged.
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Age of the current head entry. It only grows while the head sits
  // unserved, and it saturates so the starvation condition stays asserted.
  always_comb begin
    age_d = age_q;
    if (fifo_empty || pop) begin
      age_d = '0;
    end else if (age_q != AGE_LIMIT) begin
      age_d = age_q + AW'(1);
    end
  end

  // The stall decision uses the registered count and age, so pipe_stall
  // follows the triggering condition by exactly one cycle.
  always_comb begin
    pipe_stall_d = fifo_full || (age_q == AGE_LIMIT);
  end

  // Scoreboard update: clear first, then set, so that an issue in the same
  // cycle as the matching pop leaves the bit set.
  always_comb begin
    busy_d = busy_q;
    if (pop) begin
      busy_d[head_addr] = 1'b0;
    end
    if (iss_valid) begin
      busy_d[iss_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Write port: the address and data hold their last values while idle.
  always_comb begin
    rf_regwrite_d   = 1'b0;
    rf_write_addr_d = rf_write_addr_q;
    rf_write_data_d = rf_write_data_q;
    if (grant_wb) begin
      rf_regwrite_d   = 1'b1;
      rf_write_addr_d = wb_addr;
      rf_write_data_d = wb_data;
    end else if (pop && !head_is_r0) begin
      rf_regwrite_d   = 1'b1;
      rf_write_addr_d = head_addr;
      rf_write_data_d = head_data;
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------

  // FIFO storage write (data only, no reset).
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= mdu_addr;
      fifo_data_q[wr_ptr_q] <= mdu_data;
    end
  end

  // Control and output registers. Clearing count and pointers on reset
  // discards any queued entries without writing them.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      age_q           <= '0;
      pipe_stall_q    <= 1'b0;
      busy_q          <= '0;
      rf_regwrite_q   <= 1'b0;
      rf_write_addr_q <= '0;
      rf_write_data_q <= '0;
    end else begin
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      age_q           <= age_d;
      pipe_stall_q    <= pipe_stall_d;
      busy_q          <= busy_d;
      rf_regwrite_q   <= rf_regwrite_d;
      rf_write_addr_q <= rf_write_addr_d;
      rf_write_data_q <= rf_write_data_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign busy_vec      = busy_q;
  assign pipe_stall    = pipe_stall_q;
  assign rf_regwrite   = rf_regwrite_q;
  assign rf_write_addr = rf_write_addr_q;
  assign rf_write_data = rf_write_data_q;

  // -------------------------------------------------------------------------
  // Optional trace
  // -------------------------------------------------------------------------
`ifdef RF_ARB_TRACE_EN
  // The decision made in this cycle is the value rf_* will hold after this
  // edge, so the trace line matches the post-update write port.
  always @(posedge clk) begin
    if (!rst) begin
      if (grant_wb) begin
        $display("%0t rf_write_arbiter: WB  r%0d = 0x%h", $time, wb_addr, wb_data);
      end else if (pop) begin
        if (head_is_r0) begin
          $display("%0t rf_write_arbiter: MDU r0 dropped", $time);
        end else begin
          $display("%0t rf_write_arbiter: MDU r%0d = 0x%h", $time, head_addr, head_data);
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
module tb_rf_write_arbiter;

  logic        clk;
  logic        rst;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        mdu_valid;
  logic        mdu_ready;
  logic [4:0]  mdu_addr;
  logic [31:0] mdu_data;
  logic        iss_valid;
  logic [4:0]  iss_addr;
  logic [31:0] busy_vec;
  logic        pipe_stall;
  logic        rf_regwrite;
  logic [4:0]  rf_write_addr;
  logic [31:0] rf_write_data;

  int checks   = 0;
  int failures = 0;

  rf_write_arbiter #(
    .ADDR_SIZE(5), .WORD(32), .QDEPTH(2), .STARVE_LIMIT(3)
  ) dut (
    .clk(clk), .rst(rst),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .mdu_valid(mdu_valid), .mdu_ready(mdu_ready),
    .mdu_addr(mdu_addr), .mdu_data(mdu_data),
    .iss_valid(iss_valid), .iss_addr(iss_addr),
    .busy_vec(busy_vec), .pipe_stall(pipe_stall),
    .rf_regwrite(rf_regwrite), .rf_write_addr(rf_write_addr),
    .rf_write_data(rf_write_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Outputs are checked 1 time unit after the rising edge. New inputs are
  // applied at the same point, so they are in place for the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; wb_we = 1'b0; wb_addr = '0; wb_data = '0;
    mdu_valid = 1'b1; mdu_addr = 5'd5; mdu_data = 32'h55;
    iss_valid = 1'b0; iss_addr = '0;
    #1;
    chk("rst_ready_pre", mdu_ready, 0);

    // Hold reset for 2 cycles with mdu_valid offered.
    tick();
    chk("rst1_ready", mdu_ready, 0);
    chk("rst1_we", rf_regwrite, 0);
    chk("rst1_busy", busy_vec, 0);
    tick();
    chk("rst2_ready", mdu_ready, 0);
    chk("rst2_we", rf_regwrite, 0);
    chk("rst2_busy", busy_vec, 0);
    chk("rst2_stall", pipe_stall, 0);
    chk("rst2_addr", rf_write_addr, 0);
    chk("rst2_data", rf_write_data, 0);
    rst = 1'b0; mdu_valid = 1'b0;
    #1;
    chk("post_rst_ready", mdu_ready, 1);

    // WB write to r8, then a WB request to r0.
    wb_we = 1'b1; wb_addr = 5'd8; wb_data = 32'h12345678;
    tick();
    chk("wb8_we", rf_regwrite, 1);
    chk("wb8_addr", rf_write_addr, 8);
    chk("wb8_data", rf_write_data, 32'h12345678);
    wb_addr = 5'd0; wb_data = 32'hAAAA5555;
    tick();
    chk("wb0_we", rf_regwrite, 0);
    chk("wb0_addr_hold", rf_write_addr, 8);
    chk("wb0_data_hold", rf_write_data, 32'h12345678);
    wb_we = 1'b0;

    // Issue to r16, then the MDU result is queued and drained.
    iss_valid = 1'b1; iss_addr = 5'd16;
    tick();
    iss_valid = 1'b0;
    chk("iss16_busy", busy_vec, 32'h0001_0000);
    tick();
    chk("iss16_busy_hold", busy_vec, 32'h0001_0000);
    mdu_valid = 1'b1; mdu_addr = 5'd16; mdu_data = 32'hDEADBEEF;
    tick();                                  // push edge
    mdu_valid = 1'b0;
    chk("m16_no_bypass", rf_regwrite, 0);
    chk("m16_busy_pending", busy_vec, 32'h0001_0000);
    tick();                                  // pop edge
    chk("m16_we", rf_regwrite, 1);
    chk("m16_addr", rf_write_addr, 16);
    chk("m16_data", rf_write_data, 32'hDEADBEEF);
    chk("m16_busy_clr", busy_vec, 0);
    tick();
    chk("m16_idle", rf_regwrite, 0);

    // FIFO fills behind continuous WB writes to r9.
    wb_we = 1'b1; wb_addr = 5'd9; wb_data = 32'h9;
    mdu_valid = 1'b1; mdu_addr = 5'd17; mdu_data = 32'h17;
    tick();
    chk("fill1_ready", mdu_ready, 1);
    chk("fill1_wb", rf_write_addr, 9);
    mdu_addr = 5'd18; mdu_data = 32'h18;
    tick();
    mdu_valid = 1'b0;
    chk("fill2_ready", mdu_ready, 0);
    chk("fill2_stall", pipe_stall, 0);
    tick();
    chk("full_stall", pipe_stall, 1);
    chk("full_wb_we", rf_regwrite, 1);
    chk("full_wb_addr", rf_write_addr, 9);
    wb_we = 1'b0;
    tick();
    chk("drain17_we", rf_regwrite, 1);
    chk("drain17_addr", rf_write_addr, 17);
    chk("drain17_data", rf_write_data, 32'h17);
    tick();
    chk("drain18_addr", rf_write_addr, 18);
    chk("drain18_data", rf_write_data, 32'h18);
    chk("drain18_stall", pipe_stall, 0);
    chk("drain18_ready", mdu_ready, 1);
    tick();
    chk("drain_idle", rf_regwrite, 0);

    // Single entry starved by WB: stall rises 4 edges after the push edge.
    wb_we = 1'b1; wb_addr = 5'd9;
    mdu_valid = 1'b1; mdu_addr = 5'd21; mdu_data = 32'h21;
    tick();                                  // push edge
    mdu_valid = 1'b0;
    chk("starve_e0", pipe_stall, 0);
    tick();
    chk("starve_e1", pipe_stall, 0);
    tick();
    chk("starve_e2", pipe_stall, 0);
    tick();
    chk("starve_e3", pipe_stall, 0);
    tick();
    chk("starve_e4", pipe_stall, 1);
    wb_we = 1'b0;
    tick();
    chk("starve_pop_addr", rf_write_addr, 21);
    chk("starve_pop_data", rf_write_data, 32'h21);
    tick();
    chk("starve_clear", pipe_stall, 0);

    // Issue to r20 in the same cycle its earlier entry pops: set wins.
    iss_valid = 1'b1; iss_addr = 5'd20;
    tick();
    iss_valid = 1'b0;
    mdu_valid = 1'b1; mdu_addr = 5'd20; mdu_data = 32'h20;
    tick();
    mdu_valid = 1'b0;
    iss_valid = 1'b1; iss_addr = 5'd20;
    tick();
    iss_valid = 1'b0;
    chk("r20_write", rf_write_addr, 20);
    chk("r20_busy_set_wins", busy_vec, 32'h0010_0000);

    // MDU entry to r0: handshake completes and the entry is popped, but
    // nothing is written.
    mdu_valid = 1'b1; mdu_addr = 5'd0; mdu_data = 32'hBAD0;
    tick();
    mdu_valid = 1'b0;
    tick();
    chk("mr0_no_write", rf_regwrite, 0);
    chk("mr0_addr_hold", rf_write_addr, 20);
    chk("mr0_ready", mdu_ready, 1);

    // Issue to r0 is ignored.
    iss_valid = 1'b1; iss_addr = 5'd0;
    tick();
    iss_valid = 1'b0;
    chk("iss0_ignored", busy_vec, 32'h0010_0000);

    // Reset with two entries queued: neither entry is ever written.
    wb_we = 1'b1; wb_addr = 5'd9;
    iss_valid = 1'b1; iss_addr = 5'd22;
    mdu_valid = 1'b1; mdu_addr = 5'd22; mdu_data = 32'h22;
    tick();
    iss_valid = 1'b0;
    mdu_addr = 5'd23; mdu_data = 32'h23;
    tick();
    mdu_valid = 1'b0;
    chk("pre_rst_full", mdu_ready, 0);
    rst = 1'b1; wb_we = 1'b0;
    tick();
    rst = 1'b0;
    chk("mid_rst_busy", busy_vec, 0);
    chk("mid_rst_we", rf_regwrite, 0);
    chk("mid_rst_stall", pipe_stall, 0);
    #1;
    chk("mid_rst_ready", mdu_ready, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("discarded_no_write", rf_regwrite, 0);
    end
    chk("discarded_busy", busy_vec, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
